shifter_right_sequential: RTL and testbench

Multi-cycle right shifter supporting logical and arithmetic shifts, the right-direction counterpart to the combinational left logical shifter in the ALU datapath. It accepts an operand, shift amount and mode through a valid/ready handshake. It applies one binary-weighted stage per clock, stage k shifting by 2**k when bit k of the amount is set. The result is held on a valid/ready output until consumed. It serves the SRL/SRA/SRLI/SRAI paths of area-reduced and multi-cycle core variants, where a full combinational barrel shifter is too costly.

---
 rtl/shifter_right_sequential_if.sv | 37 +++
 rtl/shifter_right_sequential.sv | 97 +++++++++
 tb/tb_shifter_right_sequential.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/shifter_right_sequential_if.sv
// Request/result handshake bundle for the sequential right shifter.
// The slave side is the shifter; the master side is whoever issues requests and consumes results.
interface shifter_right_sequential_if #(
    parameter int nb_bits_data  = 32,
    parameter int nb_bits_shift = 5
);
    logic                     valid_i;
    logic                     ready_o;
    logic [nb_bits_data-1:0]  data_i;
    logic [nb_bits_shift-1:0] shift_value_i;
    logic                     arith_i;
    logic                     valid_o;
    logic                     ready_i;
    logic [nb_bits_data-1:0]  data_o;

    modport slave (
        input  valid_i,
        input  data_i,
        input  shift_value_i,
        input  arith_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output data_o
    );

    modport master (
        output valid_i,
        output data_i,
        output shift_value_i,
        output arith_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  data_o
    );
endinterface

// File: rtl/shifter_right_sequential.sv
// Multi-cycle logical/arithmetic right shifter: one binary-weighted stage per clock,
// fixed latency of nb_bits_shift cycles, result held until the consumer takes it.
module shifter_right_sequential #(
    parameter int nb_bits_data  = 32,
    parameter int nb_bits_shift = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    shifter_right_sequential_if.slave bus
);
    localparam int cnt_w = (nb_bits_shift > 1) ? $clog2(nb_bits_shift) : 1;
    localparam logic [cnt_w-1:0] last_stage = cnt_w'(nb_bits_shift - 1);

    generate
        if ((2 ** nb_bits_shift) > nb_bits_data) begin : g_bad_params
            $error("shifter_right_sequential: 2**nb_bits_shift must not exceed nb_bits_data");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [nb_bits_data-1:0]  working_q, working_d;
    logic [nb_bits_shift-1:0] amount_q, amount_d;
    logic                     fill_q, fill_d;
    logic [cnt_w-1:0]         counter_q, counter_d;

    // Candidate result of every stage; the counter picks which one applies this cycle.
    logic [nb_bits_data-1:0] stage_res [nb_bits_shift];

    generate
        for (genvar gi = 0; gi < nb_bits_shift; gi++) begin : g_stage
            localparam int step = 2 ** gi;
            assign stage_res[gi] = {{step{fill_q}}, working_q[nb_bits_data-1:step]};
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        working_d = working_q;
        amount_d  = amount_q;
        fill_d    = fill_q;
        counter_d = counter_q;
        unique case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    working_d = bus.data_i;
                    amount_d  = bus.shift_value_i;
                    // Sign is latched once so later stages never see a shifted-in bit as the MSB.
                    fill_d    = bus.arith_i & bus.data_i[nb_bits_data-1];
                    counter_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (amount_q[counter_q]) begin
                    working_d = stage_res[counter_q];
                end
                counter_d = counter_q + cnt_w'(1);
                if (counter_q == last_stage) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            working_q <= '0;
            amount_q  <= '0;
            fill_q    <= 1'b0;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            working_q <= working_d;
            amount_q  <= amount_d;
            fill_q    <= fill_d;
            counter_q <= counter_d;
        end
    end

    // Decoded straight from state so reset reaches the outputs without a clock edge.
    assign bus.ready_o = (state_q == IDLE);
    assign bus.valid_o = (state_q == DONE);
    assign bus.data_o  = working_q;
endmodule

// File: tb/tb_shifter_right_sequential.sv
// Directed and randomized checks of the sequential right shifter against a
// reference computed with the language's own >> and >>> operators.
module tb_shifter_right_sequential;
    localparam int W = 32;
    localparam int S = 5;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   total = 0;
    int   bad = 0;

    shifter_right_sequential_if #(.nb_bits_data(W), .nb_bits_shift(S)) bus ();

    shifter_right_sequential #(.nb_bits_data(W), .nb_bits_shift(S)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [S-1:0] s,
                                               input logic a);
        logic signed [W-1:0] sd;
        sd = $signed(d);
        if (a) return W'(sd >>> s);
        return d >> s;
    endfunction

    // One full request: accept, latency, optional stall, output handshake.
    task automatic run_req(input logic [W-1:0] d, input logic [S-1:0] s, input logic a,
                           input int stall, input bit toggle);
        logic [W-1:0] exp;
        exp = ref_shift(d, s, a);
        check("idle_ready", W'(bus.ready_o), W'(1));
        bus.valid_i       = 1'b1;
        bus.data_i        = d;
        bus.shift_value_i = s;
        bus.arith_i       = a;
        bus.ready_i       = 1'b0;
        tick();
        bus.valid_i = 1'b0;
        check("accept_ready_low", W'(bus.ready_o), W'(0));
        for (int k = 1; k < S; k++) begin
            if (toggle) begin
                bus.valid_i       = 1'b1;
                bus.data_i        = $urandom;
                bus.shift_value_i = S'($urandom);
                bus.arith_i       = 1'($urandom);
            end
            tick();
            check("shift_valid_low", W'(bus.valid_o), W'(0));
            check("shift_ready_low", W'(bus.ready_o), W'(0));
        end
        bus.valid_i = 1'b0;
        tick();
        check("done_valid", W'(bus.valid_o), W'(1));
        check("done_data", bus.data_o, exp);
        for (int k = 0; k < stall; k++) begin
            tick();
            check("stall_valid", W'(bus.valid_o), W'(1));
            check("stall_ready", W'(bus.ready_o), W'(0));
            check("stall_data", bus.data_o, exp);
        end
        bus.ready_i = 1'b1;
        tick();
        check("handshake_valid_low", W'(bus.valid_o), W'(0));
        check("handshake_ready_high", W'(bus.ready_o), W'(1));
        $display("req data=%h shift=%0d arith=%0d stall=%0d toggle=%0d exp=%h got=%h",
                 d, s, a, stall, toggle, exp, bus.data_o);
    endtask

    initial begin
        bus.valid_i       = 1'b0;
        bus.data_i        = '0;
        bus.shift_value_i = '0;
        bus.arith_i       = 1'b0;
        bus.ready_i       = 1'b1;

        // Power-on reset.
        #1;
        check("por_ready", W'(bus.ready_o), W'(1));
        check("por_valid", W'(bus.valid_o), W'(0));
        check("por_data", bus.data_o, '0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // Directed cases.
        run_req(32'hF000_0001, 5'd4, 1'b0, 0, 1'b0);
        run_req(32'h8000_0000, 5'd31, 1'b1, 0, 1'b0);
        run_req(32'h8000_0000, 5'd31, 1'b0, 0, 1'b0);
        run_req(32'h7FFF_FFFF, 5'd31, 1'b1, 0, 1'b0);
        run_req(32'hDEAD_BEEF, 5'd0, 1'b1, 0, 1'b0);
        run_req(32'h8765_4321, 5'd13, 1'b1, 10, 1'b0);
        run_req(32'h1234_5678, 5'd7, 1'b0, 0, 1'b1);

        // Asynchronous reset while a result is being held: outputs clear without an edge.
        bus.valid_i       = 1'b1;
        bus.data_i        = 32'hCAFE_F00D;
        bus.shift_value_i = 5'd3;
        bus.arith_i       = 1'b0;
        bus.ready_i       = 1'b0;
        tick();
        bus.valid_i = 1'b0;
        for (int k = 0; k < S; k++) tick();
        check("pre_reset_valid", W'(bus.valid_o), W'(1));
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_ready", W'(bus.ready_o), W'(1));
        check("async_rst_valid", W'(bus.valid_o), W'(0));
        check("async_rst_data", bus.data_o, '0);
        bus.ready_i = 1'b1;
        tick();
        rst_ni = 1'b1;
        tick();

        // Abort at stage 2: no result may ever appear.
        bus.valid_i       = 1'b1;
        bus.data_i        = 32'hFFFF_FFFF;
        bus.shift_value_i = 5'h1F;
        bus.arith_i       = 1'b0;
        tick();
        bus.valid_i = 1'b0;
        tick();
        tick();
        #2 rst_ni = 1'b0;
        #1;
        check("abort_valid", W'(bus.valid_o), W'(0));
        check("abort_ready", W'(bus.ready_o), W'(1));
        for (int k = 0; k < S + 1; k++) begin
            tick();
            check("abort_hold_valid", W'(bus.valid_o), W'(0));
        end
        rst_ni = 1'b1;
        tick();
        check("post_abort_ready", W'(bus.ready_o), W'(1));
        check("post_abort_valid", W'(bus.valid_o), W'(0));
        run_req(32'h0000_0100, 5'd8, 1'b0, 0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            run_req($urandom, S'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
